// File: rtl/pe_layer_scheduler_if.sv
// pe_layer_scheduler_if
//   Bundles the HPS Avalon-MM slave port and the PE-controller job port of
//   the layer scheduler.
//   slave  : scheduler side (takes bus requests, drives PE job signals)
//   master : HPS / PE-controller side
// Signals
//   chipselect, write, address[3:0], writedata[31:0] -> register access
//   readdata[31:0], irq                              <- register read / interrupt
//   pe_start, pe_in_base[IN_AW], pe_out_addr[OUT_AW] <- per-pixel job
//   pe_busy                                          -> PE controller status
interface pe_layer_scheduler_if #(
  parameter int IN_AW  = 17,
  parameter int OUT_AW = 15
);
  logic              chipselect;
  logic              write;
  logic [3:0]        address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic              pe_start;
  logic [IN_AW-1:0]  pe_in_base;
  logic [OUT_AW-1:0] pe_out_addr;
  logic              pe_busy;

  modport slave (
    input  chipselect, write, address, writedata, pe_busy,
    output readdata, irq, pe_start, pe_in_base, pe_out_addr
  );

  modport master (
    output chipselect, write, address, writedata, pe_busy,
    input  readdata, irq, pe_start, pe_in_base, pe_out_addr
  );
endinterface

// File: rtl/pe_layer_scheduler.sv
// pe_layer_scheduler
//   Walks one conv layer over the PE array: one PE-controller job per output
//   pixel. HPS programs the geometry over Avalon-MM and writes CTRL.start;
//   the block then drives input base / output address, pulses pe_start and
//   waits for each job to finish, with no per-pixel HPS involvement.
// Ports
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus        : pe_layer_scheduler_if.slave (Avalon-MM regs + PE job port)
// Register map
//   0 CTRL (bit0 start, bit1 abort, self-clearing)  1 STATUS (busy/done/err/aborted)
//   2 OUT_W 3 OUT_H 4 IN_BASE 5 OUT_BASE 6 IN_COL_STEP 7 IN_ROW_STEP
//   8 OUT_STEP 9 PIX_CNT (RO) 10 PERF (RO)
// Configuration
//   PERF_CNT_EN : when defined, reg 10 is a saturating 32-bit busy-cycle
//                 counter; otherwise reg 10 reads 0.
module pe_layer_scheduler #(
  parameter int IN_AW   = 17,
  parameter int OUT_AW  = 15,
  parameter int DIM_W   = 11,
  parameter int ACK_TMO = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  pe_layer_scheduler_if.slave bus
);
  localparam int TMR_W = $clog2(ACK_TMO + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TMO - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ACK, WAIT_DONE, ADVANCE, FINISH
  } state_t;

  state_t state, state_nxt;

  // configuration registers
  logic [DIM_W-1:0]   out_w, out_h, col_step, row_step, out_step;
  logic [IN_AW-1:0]   in_base;
  logic [OUT_AW-1:0]  out_base;

  // layer walk state
  logic [DIM_W-1:0]   col, row;
  logic [IN_AW-1:0]   row_base, col_addr;
  logic [OUT_AW-1:0]  out_addr;
  logic [2*DIM_W-1:0] pix_cnt;
  logic [TMR_W-1:0]   tmr;

  logic st_done, st_err, st_aborted;
  logic start_req, abort_req, abort_pend, busy_q;
  logic busy;
  logic [31:0] perf;

  // host decode
  logic wr, rd, ctrl_wr, stat_wr, cfg_wr;
  assign wr      = bus.chipselect &  bus.write;
  assign rd      = bus.chipselect & ~bus.write;
  assign ctrl_wr = wr && bus.address == 4'd0;
  assign stat_wr = wr && bus.address == 4'd1;
  assign cfg_wr  = wr && !busy;

  // start and abort in one write: abort wins, and an abort in IDLE is a no-op
  logic start_ok, dims_ok, abort_hit, fall, timeout, last_col, last_pix;
  assign start_ok  = start_req && !abort_req;
  assign dims_ok   = out_w != '0 && out_h != '0;
  assign abort_hit = abort_req | abort_pend;
  assign fall      = busy_q & ~bus.pe_busy;
  assign timeout   = !bus.pe_busy && tmr == TMR_LAST;
  assign last_col  = col == out_w - DIM_W'(1);
  assign last_pix  = last_col && row == out_h - DIM_W'(1);

  logic [IN_AW-1:0] row_base_nxt;
  assign row_base_nxt = row_base + IN_AW'(row_step);

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_ok && dims_ok) state_nxt = ISSUE;
      ISSUE:     state_nxt = abort_hit ? IDLE : WAIT_ACK;
      WAIT_ACK:  if (abort_hit)        state_nxt = IDLE;
                 else if (bus.pe_busy) state_nxt = WAIT_DONE;
                 else if (timeout)     state_nxt = IDLE;
      WAIT_DONE: if (fall) state_nxt = abort_hit ? IDLE : ADVANCE;
      ADVANCE:   if (last_pix)       state_nxt = FINISH;
                 else if (abort_hit) state_nxt = IDLE;
                 else                state_nxt = ISSUE;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy            = state != IDLE;
    bus.pe_start    = state == ISSUE;
    bus.pe_in_base  = col_addr;
    bus.pe_out_addr = out_addr;
    bus.irq         = st_done | st_err;
  end

  // datapath, status and registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_w <= '0; out_h <= '0; col_step <= '0; row_step <= '0; out_step <= '0;
      in_base <= '0; out_base <= '0;
      col <= '0; row <= '0; row_base <= '0; col_addr <= '0; out_addr <= '0;
      pix_cnt <= '0; tmr <= '0;
      st_done <= 1'b0; st_err <= 1'b0; st_aborted <= 1'b0;
      start_req <= 1'b0; abort_req <= 1'b0; abort_pend <= 1'b0; busy_q <= 1'b0;
    end else begin
      busy_q     <= bus.pe_busy;
      start_req  <= ctrl_wr && bus.writedata[0];
      abort_req  <= ctrl_wr && bus.writedata[1];
      // an abort seen while a job runs is held until that job drains
      abort_pend <= (state == WAIT_DONE) && abort_hit;

      if (cfg_wr)
        case (bus.address)
          4'd2: out_w    <= bus.writedata[DIM_W-1:0];
          4'd3: out_h    <= bus.writedata[DIM_W-1:0];
          4'd4: in_base  <= bus.writedata[IN_AW-1:0];
          4'd5: out_base <= bus.writedata[OUT_AW-1:0];
          4'd6: col_step <= bus.writedata[DIM_W-1:0];
          4'd7: row_step <= bus.writedata[DIM_W-1:0];
          4'd8: out_step <= bus.writedata[DIM_W-1:0];
          default: ;
        endcase

      // clears first so a same-cycle set wins
      if (stat_wr) begin
        if (bus.writedata[1]) st_done    <= 1'b0;
        if (bus.writedata[2]) st_err     <= 1'b0;
        if (bus.writedata[3]) st_aborted <= 1'b0;
      end

      case (state)
        IDLE: if (start_ok) begin
          if (dims_ok) begin
            row_base <= in_base;
            col_addr <= in_base;
            out_addr <= out_base;
            col      <= '0;
            row      <= '0;
            pix_cnt  <= '0;
          end else begin
            st_done <= 1'b1;
          end
        end
        ISSUE: begin
          // tmr holds cycles elapsed since pe_start
          tmr <= TMR_W'(1);
          if (abort_hit) st_aborted <= 1'b1;
        end
        WAIT_ACK: begin
          tmr <= tmr + TMR_W'(1);
          if (abort_hit)                   st_aborted <= 1'b1;
          else if (!bus.pe_busy && timeout) st_err    <= 1'b1;
        end
        WAIT_DONE: if (fall && abort_hit) begin
          pix_cnt    <= pix_cnt + 1'b1;
          st_aborted <= 1'b1;
        end
        ADVANCE: begin
          pix_cnt  <= pix_cnt + 1'b1;
          out_addr <= out_addr + OUT_AW'(out_step);
          if (!last_col) begin
            col      <= col + DIM_W'(1);
            col_addr <= col_addr + IN_AW'(col_step);
          end else begin
            col      <= '0;
            row      <= row + DIM_W'(1);
            row_base <= row_base_nxt;
            col_addr <= row_base_nxt;
          end
          if (abort_hit && !last_pix) st_aborted <= 1'b1;
        end
        FINISH: st_done <= 1'b1;
        default: ;
      endcase
    end

`ifdef PERF_CNT_EN
  // counts every non-IDLE cycle of the layer; cleared on start accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                      perf <= '0;
    else if (state == IDLE && start_ok) perf <= '0;
    else if (busy && perf != '1)     perf <= perf + 32'd1;
`else
  assign perf = '0;
`endif

  // registered read port
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.readdata <= '0;
    else if (rd)
      case (bus.address)
        4'd1:    bus.readdata <= {28'd0, st_aborted, st_err, st_done, busy};
        4'd2:    bus.readdata <= 32'(out_w);
        4'd3:    bus.readdata <= 32'(out_h);
        4'd4:    bus.readdata <= 32'(in_base);
        4'd5:    bus.readdata <= 32'(out_base);
        4'd6:    bus.readdata <= 32'(col_step);
        4'd7:    bus.readdata <= 32'(row_step);
        4'd8:    bus.readdata <= 32'(out_step);
        4'd9:    bus.readdata <= 32'(pix_cnt);
        4'd10:   bus.readdata <= perf;
        default: bus.readdata <= '0;
      endcase
endmodule
